// File: rtl/acc_requantizer.sv
// Requantizes wide MAC accumulator results (rounding shift, optional ReLU, saturation)
// and buffers them in a show-ahead FIFO so a stalled consumer never stalls the MAC.
module acc_requantizer #(
  parameter int unsigned ACCW   = 40,
  parameter int unsigned OW     = 16,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [ACCW-1:0]          in_acc,
  input  logic [5:0]               shift,
  input  logic                     relu_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OW-1:0]            out_data,
  output logic                     sat_flag,
  output logic                     ovf,
  input  logic                     clr_ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [5:0]  ShiftMax = 6'(ACCW - 1);
  localparam logic [AW:0] LevelMax = (AW + 1)'(DEPTH);

  // S1: rounding right shift, one guard bit above ACCW so the rounding add cannot wrap
  logic [5:0]    shamt;
  logic [ACCW:0] acc_ext, rnd, sum;
  logic [ACCW:0] s1_r_d, s1_r_q;
  logic          s1_valid_q;

  always_comb begin
    shamt   = (shift > ShiftMax) ? ShiftMax : shift;
    acc_ext = {SIGNED & in_acc[ACCW-1], in_acc};
    rnd     = '0;
    if (shamt != 6'd0) rnd[shamt - 6'd1] = 1'b1;
    sum = acc_ext + rnd;
    if (SIGNED) s1_r_d = $unsigned($signed(sum) >>> shamt);
    else        s1_r_d = sum >> shamt;
  end

  // S2: ReLU and saturation; ReLU zeroing is not counted as saturation
  logic [OW-1:0] s2_data_d, s2_data_q;
  logic          s2_sat_d, s2_sat_q;
  logic          s2_valid_q;

  always_comb begin
    s2_data_d = s1_r_q[OW-1:0];
    s2_sat_d  = 1'b0;
    if (SIGNED) begin
      if (relu_en && s1_r_q[ACCW]) begin
        s2_data_d = '0;
      end else if (s1_r_q[ACCW:OW-1] != {(ACCW - OW + 2){s1_r_q[ACCW]}}) begin
        s2_sat_d  = 1'b1;
        s2_data_d = s1_r_q[ACCW] ? {1'b1, {(OW - 1){1'b0}}} : {1'b0, {(OW - 1){1'b1}}};
      end
    end else if (|s1_r_q[ACCW:OW]) begin
      s2_sat_d  = 1'b1;
      s2_data_d = '1;
    end
  end

  // Output FIFO
  logic [OW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [AW:0]   level_d, level_q;
  logic          ovf_d, ovf_q;
  logic          pop, push, drop, full;

  always_comb begin
    full     = (level_q == LevelMax);
    pop      = out_valid & out_ready;
    push     = s2_valid_q & (~full | pop);
    drop     = s2_valid_q & full & ~pop;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
    ovf_d    = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      s1_r_q     <= s1_r_d;
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= s2_data_d;
      s2_sat_q   <= s2_sat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= s2_data_q;
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign sat_flag  = s2_valid_q & s2_sat_q;
  assign ovf       = ovf_q;
  assign level     = level_q;

endmodule
